// File: rtl/rv32i_types.sv
// Shared register-file types for the writeback port arbiter.
// Used by wb_port_arbiter and its result FIFO.
package rv32i_types;

   typedef logic [4:0]  rv32i_reg;
   typedef logic [31:0] rv32i_word;

   typedef enum logic [1:0] {
      NONE,
      PIPE,
      DRAIN,
      BYPASS
   } wb_src_t;

   typedef struct packed {
      rv32i_reg  rd;
      rv32i_word data;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular FIFO of pending MDU results awaiting a regfile write slot.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_result_fifo
   import rv32i_types::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  wb_entry_t push_entry_i,
   input  logic      pop_i,
   output wb_entry_t head_o,
   output logic      empty_o,
   output logic      full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   wb_entry_t   mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage has no reset; entries are only visible through the reset pointers.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
      end
   end

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB stage and buffered MDU results,
// with starvation-forced drains and an MDU pending-destination scoreboard. Optional: WB_BYPASS_EN.
module wb_port_arbiter
   import rv32i_types::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_load,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   input  logic        issue_mdu,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   output logic        hazard,
   output logic        wb_stall,
   output logic        regfile_load,
   output logic [4:0]  regfile_rd,
   output logic [31:0] regfile_in
);

   localparam int             CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;
   logic [31:0]   pending_q, pending_d;

   wb_entry_t head;
   wb_entry_t push_entry;
   logic      fifo_empty, fifo_full;
   logic      push, pop, slot_free, mdu_accept;
   wb_src_t   src;

   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .empty_o      (fifo_empty),
      .full_o       (fifo_full)
   );

   assign wb_stall   = !fifo_empty && (starve_q == LIMIT);
   assign slot_free  = !pipe_load || (pipe_rd == 5'd0) || wb_stall;
   assign pop        = !fifo_empty && slot_free;
   assign mdu_ready  = !fifo_full || pop;
   assign mdu_accept = mdu_valid && mdu_ready;
   assign push_entry = '{rd: mdu_rd, data: mdu_data};

   assign hazard = ((issue_rs1 != 5'd0) && pending_q[issue_rs1]) ||
                   ((issue_rs2 != 5'd0) && pending_q[issue_rs2]) ||
                   ((issue_rd  != 5'd0) && pending_q[issue_rd]);

   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      src          = NONE;
      regfile_load = 1'b0;
      regfile_rd   = 5'd0;
      regfile_in   = 32'd0;
      if (pop) begin
         src = DRAIN;
      end else if (pipe_load && (pipe_rd != 5'd0)) begin
         src = PIPE;
`ifdef WB_BYPASS_EN
      end else if (fifo_empty && slot_free && mdu_accept) begin
         src = BYPASS;
`endif
      end
      unique case (src)
         DRAIN: begin
            regfile_load = (head.rd != 5'd0);
            regfile_rd   = head.rd;
            regfile_in   = head.data;
         end
         PIPE: begin
            regfile_load = 1'b1;
            regfile_rd   = pipe_rd;
            regfile_in   = pipe_data;
         end
         BYPASS: begin
            regfile_load = (mdu_rd != 5'd0);
            regfile_rd   = mdu_rd;
            regfile_in   = mdu_data;
         end
         default: ;
      endcase
   end

   assign push = mdu_accept && (src != BYPASS);

   // Set after clear so a same-cycle issue to the committing rd stays pending.
   always_comb begin
      pending_d = pending_q;
      if (src == DRAIN) begin
         pending_d[head.rd] = 1'b0;
      end else if (src == BYPASS) begin
         pending_d[mdu_rd] = 1'b0;
      end
      if (issue_mdu && !hazard && (issue_rd != 5'd0)) begin
         pending_d[issue_rd] = 1'b1;
      end
   end

   always_comb begin
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q == LIMIT) begin
         starve_d = LIMIT;
      end else begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q  <= '0;
         pending_q <= '0;
      end else begin
         starve_q  <= starve_d;
         pending_q <= pending_d;
      end
   end

endmodule
